// File: rtl/lookup2_absorb.sv
// lookup2 message absorber: packs a byte stream into 12-byte blocks, issues mixes, returns the final c.
// Optional build macro LOOKUP2_ABSORB_INITVAL_PORT_EN adds an initval port that replaces INITVAL.
module lookup2_absorb #(
   parameter logic [31:0] INITVAL = 32'h0
) (
   input  logic        CLK,
   input  logic        RST,
`ifdef LOOKUP2_ABSORB_INITVAL_PORT_EN
   input  logic [31:0] initval,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   input  logic        in_empty,
   output logic        mix_start,
   output logic [31:0] mix_a,
   output logic [31:0] mix_b,
   output logic [31:0] mix_c,
   output logic        mix_final,
   input  logic        mix_done,
   input  logic [31:0] res_a,
   input  logic [31:0] res_b,
   input  logic [31:0] res_c,
   output logic        hash_valid,
   output logic [31:0] hash_out,
   output logic [31:0] hash_len
);

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      MIX_WAIT,
      FINAL_ISSUE,
      FINAL_WAIT,
      DONE
   } state_t;

   localparam logic [31:0] GOLDEN = 32'h9e3779b9;

   state_t      state;
   logic [31:0] a, b, c, len;
   logic [95:0] blk;
   logic [3:0]  idx;
   logic        pend_final;
   logic        empty_req;

   logic [31:0] init_c;
   logic [31:0] base_a, base_b, base_c, base_len, nlen;
   logic [95:0] base_blk, nblk;
   logic [3:0]  base_idx, nidx;
   logic [31:0] tail_c;
   logic        take;

`ifdef LOOKUP2_ABSORB_INITVAL_PORT_EN
   assign init_c = initval;
`else
   assign init_c = INITVAL;
`endif

   // In IDLE the accepted byte opens a new message, so operands come from the start-of-message values.
   always_comb begin
      base_a   = a;
      base_b   = b;
      base_c   = c;
      base_len = len;
      base_blk = blk;
      base_idx = idx;
      if (state == IDLE) begin
         base_a   = GOLDEN;
         base_b   = GOLDEN;
         base_c   = init_c;
         base_len = '0;
         base_blk = '0;
         base_idx = '0;
      end
      nblk = base_blk;
      nblk[{base_idx, 3'b000} +: 8] = in_data;
      nidx   = base_idx + 4'd1;
      nlen   = base_len + 32'd1;
      // Tail bytes 8..10 sit one byte up in c; the low byte is reserved for the length.
      tail_c = {nblk[87:64], 8'h00};
      take   = in_valid && in_ready && (state == IDLE || state == ABSORB);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         a          <= '0;
         b          <= '0;
         c          <= '0;
         len        <= '0;
         blk        <= '0;
         idx        <= '0;
         pend_final <= 1'b0;
         empty_req  <= 1'b0;
         in_ready   <= 1'b0;
         mix_start  <= 1'b0;
         mix_final  <= 1'b0;
         mix_a      <= '0;
         mix_b      <= '0;
         mix_c      <= '0;
         hash_valid <= 1'b0;
         hash_out   <= '0;
         hash_len   <= '0;
      end else begin
         mix_start  <= 1'b0;
         hash_valid <= 1'b0;
         case (state)
            IDLE, ABSORB: begin
               if (take) begin
                  a   <= base_a;
                  b   <= base_b;
                  c   <= base_c;
                  blk <= nblk;
                  idx <= nidx;
                  len <= nlen;
                  if (nidx == 4'd12) begin
                     mix_a      <= base_a + nblk[31:0];
                     mix_b      <= base_b + nblk[63:32];
                     mix_c      <= base_c + nblk[95:64];
                     mix_final  <= 1'b0;
                     mix_start  <= 1'b1;
                     pend_final <= in_last;
                     in_ready   <= 1'b0;
                     state      <= MIX_WAIT;
                  end else if (in_last) begin
                     mix_a     <= base_a + nblk[31:0];
                     mix_b     <= base_b + nblk[63:32];
                     mix_c     <= base_c + tail_c + nlen;
                     mix_final <= 1'b1;
                     mix_start <= 1'b1;
                     in_ready  <= 1'b0;
                     state     <= FINAL_ISSUE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= ABSORB;
                  end
               end else if (state == IDLE && in_empty) begin
                  a         <= GOLDEN;
                  b         <= GOLDEN;
                  c         <= init_c;
                  len       <= '0;
                  blk       <= '0;
                  idx       <= '0;
                  empty_req <= 1'b1;
                  in_ready  <= 1'b0;
                  state     <= ABSORB;
               end else if (state == IDLE) begin
                  in_ready <= 1'b1;
               end else if (empty_req) begin
                  mix_a     <= a;
                  mix_b     <= b;
                  mix_c     <= c + len;
                  mix_final <= 1'b1;
                  mix_start <= 1'b1;
                  empty_req <= 1'b0;
                  state     <= FINAL_ISSUE;
               end
            end
            MIX_WAIT: begin
               if (mix_done) begin
                  a   <= res_a;
                  b   <= res_b;
                  c   <= res_c;
                  blk <= '0;
                  idx <= '0;
                  if (pend_final) begin
                     mix_a      <= res_a;
                     mix_b      <= res_b;
                     mix_c      <= res_c + len;
                     mix_final  <= 1'b1;
                     mix_start  <= 1'b1;
                     pend_final <= 1'b0;
                     state      <= FINAL_ISSUE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= ABSORB;
                  end
               end
            end
            FINAL_ISSUE: state <= FINAL_WAIT;
            FINAL_WAIT: begin
               if (mix_done) begin
                  hash_out   <= res_c;
                  hash_len   <= len;
                  hash_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
